// File: rtl/dma_engine_status_responder.sv
// Engine-side status responder: per-engine CTRL/LENGTH/STATUS/DONE_BYTES registers plus the
// STATUS/CONTROL byte pair and beat accounting for whichever engine the arbiter grants.
module dma_engine_status_responder #(
  parameter int C_NUM_ENGINES   = 2,
  parameter int C_QUANTUM_BYTES = 4096,
  parameter int C_BEAT_BYTES_W  = 6
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             cfg_we,
  input  logic [$clog2(C_NUM_ENGINES)-1:0] cfg_engine,
  input  logic [1:0]                       cfg_addr,
  input  logic [31:0]                      cfg_wdata,
  output logic [31:0]                      cfg_rdata,
  output logic                             cfg_err,
  output logic [C_NUM_ENGINES-1:0]         enable_engines,
  input  logic [$clog2(C_NUM_ENGINES)-1:0] active_engine,
  input  logic                             engine_valid,
  input  logic                             operation_in_course,
  output logic [7:0]                       status_byte,
  output logic [7:0]                       control_byte,
  input  logic                             pause_req,
  input  logic                             beat_valid,
  input  logic [C_BEAT_BYTES_W-1:0]        beat_bytes,
  output logic [C_NUM_ENGINES-1:0]         irq
);
  // state  | meaning
  // S_IDLE | no operation in course, waiting for a usable grant
  // S_RUN  | moving beats for active_engine
  // S_END  | end-of-operation flagged, held until the grant is withdrawn
  localparam int         EW       = $clog2(C_NUM_ENGINES);
  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_LENGTH = 2'd1;
  localparam logic [1:0] A_STATUS = 2'd2;
  localparam logic [1:0] A_DONE   = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_END} state_t;
  state_t state, state_nxt;

  logic [C_NUM_ENGINES-1:0] enable, stop_req, irq_en, pending_irq, stopped;
  logic [31:0]              remaining  [C_NUM_ENGINES];
  logic [31:0]              done_bytes [C_NUM_ENGINES];
  logic [31:0]              qcnt, qcnt_nxt, beat_ext, act_rem, sub_bytes, rem_nxt, rd_mux;
  logic                     pause_q, beat_take, hit_zero, beat_end, len_wr, len_reject;

  always_comb begin
    stopped = '0;
    for (int e = 0; e < C_NUM_ENGINES; e++)
      stopped[e] = (remaining[e] == 32'd0) | stop_req[e] | ~enable[e];
  end

  // Beats are gated by the raw pause request; CONTROL_BYTE[5] only reports it a cycle later.
  assign beat_ext  = 32'(beat_bytes);
  assign act_rem   = remaining[active_engine];
  assign beat_take = (state == S_RUN) && engine_valid && beat_valid && !pause_req;
  assign sub_bytes = (beat_ext > act_rem) ? act_rem : beat_ext;
  assign rem_nxt   = act_rem - sub_bytes;
  assign qcnt_nxt  = qcnt + beat_ext;
  assign hit_zero  = beat_take && (act_rem != 32'd0) && (rem_nxt == 32'd0);
  assign beat_end  = beat_take && ((rem_nxt == 32'd0) || (qcnt_nxt >= 32'(C_QUANTUM_BYTES)));

  assign len_wr     = cfg_we && (cfg_addr == A_LENGTH);
  assign len_reject = len_wr && (cfg_engine == active_engine) && (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (engine_valid && operation_in_course && !stopped[active_engine]) state_nxt = S_RUN;
      S_RUN: begin
        if (!engine_valid)                          state_nxt = S_IDLE;
        else if (beat_end || stopped[active_engine]) state_nxt = S_END;
      end
      S_END:   if (!engine_valid) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    control_byte = {2'b00, pause_q, 1'b0, (state == S_END), 3'b000};
  end

  // Forced low during reset so the byte clears the moment rst_n falls.
  assign status_byte = rst_n ? {pending_irq[active_engine], 3'b000, stopped[active_engine],
                                2'b00, enable[active_engine]} : 8'h00;
  assign enable_engines = enable;
  assign irq            = pending_irq & irq_en;

  always_comb begin
    rd_mux = '0;
    unique case (cfg_addr)
      A_CTRL:   rd_mux = {29'd0, irq_en[cfg_engine], stop_req[cfg_engine], enable[cfg_engine]};
      A_LENGTH: rd_mux = remaining[cfg_engine];
      A_STATUS: rd_mux = {24'd0, pending_irq[cfg_engine], 3'b000, stopped[cfg_engine], 2'b00,
                          enable[cfg_engine]};
      A_DONE:   rd_mux = done_bytes[cfg_engine];
      default:  rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_rdata   <= '0;
      cfg_err     <= 1'b0;
      pause_q     <= 1'b0;
      qcnt        <= '0;
      enable      <= '0;
      stop_req    <= '0;
      irq_en      <= '0;
      pending_irq <= '0;
      for (int e = 0; e < C_NUM_ENGINES; e++) begin
        remaining[e]  <= '0;
        done_bytes[e] <= '0;
      end
    end else begin
      cfg_rdata <= rd_mux;
      cfg_err   <= len_reject;
      pause_q   <= pause_req;
      if (state == S_IDLE && state_nxt == S_RUN) qcnt <= '0;
      else if (beat_take)                        qcnt <= qcnt_nxt;
      for (int e = 0; e < C_NUM_ENGINES; e++) begin
        if (cfg_we && cfg_addr == A_CTRL && cfg_engine == EW'(e)) begin
          enable[e]   <= cfg_wdata[0];
          stop_req[e] <= cfg_wdata[1];
          irq_en[e]   <= cfg_wdata[2];
          if (cfg_wdata[3]) pending_irq[e] <= 1'b0;
        end
        if (len_wr && !len_reject && cfg_engine == EW'(e)) begin
          remaining[e]  <= cfg_wdata;
          done_bytes[e] <= '0;
          stop_req[e]   <= 1'b0;
        end
        if (beat_take && active_engine == EW'(e)) begin
          remaining[e]  <= rem_nxt;
          done_bytes[e] <= done_bytes[e] + sub_bytes;
        end
        // Placed after the CTRL clear so a same-cycle completion keeps the interrupt pending.
        if (hit_zero && active_engine == EW'(e)) pending_irq[e] <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_dma_engine_status_responder.sv
// Bench for dma_engine_status_responder: register table, directed corner sequences and
// randomized traffic checked every cycle against a behavioural model.
module tb_dma_engine_status_responder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_we, cfg_engine, active_engine, engine_valid, operation_in_course;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata, cfg_rdata;
  logic        cfg_err, pause_req, beat_valid;
  logic [1:0]  enable_engines, irq;
  logic [7:0]  status_byte, control_byte;
  logic [5:0]  beat_bytes;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dma_engine_status_responder dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_engine(cfg_engine), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .cfg_err(cfg_err),
    .enable_engines(enable_engines), .active_engine(active_engine), .engine_valid(engine_valid),
    .operation_in_course(operation_in_course), .status_byte(status_byte),
    .control_byte(control_byte), .pause_req(pause_req), .beat_valid(beat_valid),
    .beat_bytes(beat_bytes), .irq(irq)
  );

  // Behavioural model: per-engine registers plus "busy"/"ended" flags for the current grant.
  bit          m_en[2], m_stop[2], m_ien[2], m_pend[2];
  int unsigned m_rem[2], m_done[2];
  bit          m_busy, m_ended, m_pause_d, m_err;
  longint      m_moved;
  logic [31:0] m_rdata;

  task automatic model_reset();
    for (int e = 0; e < 2; e++) begin
      m_en[e] = 0; m_stop[e] = 0; m_ien[e] = 0; m_pend[e] = 0; m_rem[e] = 0; m_done[e] = 0;
    end
    m_busy = 0; m_ended = 0; m_pause_d = 0; m_err = 0; m_moved = 0; m_rdata = '0;
  endtask

  function automatic bit m_stopped(int e);
    return (m_rem[e] == 0) || m_stop[e] || !m_en[e];
  endfunction

  function automatic logic [31:0] m_status(int e);
    return 32'((int'(m_pend[e]) << 7) | (int'(m_stopped(e)) << 3) | int'(m_en[e]));
  endfunction

  function automatic logic [31:0] m_read(int e, int addr);
    case (addr)
      0:       return 32'(int'(m_en[e]) | (int'(m_stop[e]) << 1) | (int'(m_ien[e]) << 2));
      1:       return m_rem[e];
      2:       return m_status(e);
      default: return m_done[e];
    endcase
  endfunction

  task automatic model_step();
    int          a      = int'(active_engine);
    int          c      = int'(cfg_engine);
    bit          busy0  = m_busy;
    bit          ended0 = m_ended;
    bit          stp0   = m_stopped(a);
    int unsigned rem0   = m_rem[a];
    int unsigned beat   = int'(beat_bytes);
    bit          take   = busy0 && !ended0 && engine_valid && beat_valid && !pause_req;
    int unsigned sub    = take ? ((beat < rem0) ? beat : rem0) : 0;
    longint      moved_n = m_moved + (take ? longint'(beat) : 0);
    m_rdata   = m_read(c, int'(cfg_addr));
    m_pause_d = pause_req;
    m_err     = 0;
    if (cfg_we) begin
      if (cfg_addr == 2'd0) begin
        m_en[c] = cfg_wdata[0]; m_stop[c] = cfg_wdata[1]; m_ien[c] = cfg_wdata[2];
        if (cfg_wdata[3]) m_pend[c] = 0;
      end else if (cfg_addr == 2'd1) begin
        if (c == a && busy0) m_err = 1;
        else begin m_rem[c] = cfg_wdata; m_done[c] = 0; m_stop[c] = 0; end
      end
    end
    if (take) begin
      m_rem[a]  = rem0 - sub;
      m_done[a] = m_done[a] + sub;
      if (rem0 != 0 && rem0 == sub) m_pend[a] = 1;
    end
    if (!busy0) begin
      if (engine_valid && operation_in_course && !stp0) begin m_busy = 1; m_moved = 0; end
    end else if (!ended0) begin
      if (!engine_valid) m_busy = 0;
      else begin
        if (take) m_moved = moved_n;
        if (stp0 || (take && (rem0 == sub || moved_n >= 4096))) m_ended = 1;
      end
    end else if (!engine_valid) begin
      m_busy = 0; m_ended = 0;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check("status_byte", 32'(status_byte), m_status(int'(active_engine)));
    @(posedge clk);
    model_step();
    #1;
    check("control_byte", 32'(control_byte), 32'((int'(m_ended) << 3) | (int'(m_pause_d) << 5)));
    check("irq", 32'(irq), 32'({m_pend[1] & m_ien[1], m_pend[0] & m_ien[0]}));
    check("enable_engines", 32'(enable_engines), 32'({m_en[1], m_en[0]}));
    check("cfg_err", 32'(cfg_err), 32'(m_err));
    check("cfg_rdata", cfg_rdata, m_rdata);
  endtask

  task automatic cfg_write(input logic eng, input logic [1:0] addr, input logic [31:0] data);
    cfg_we = 1; cfg_engine = eng; cfg_addr = addr; cfg_wdata = data;
    tick();
    cfg_we = 0;
  endtask

  task automatic cfg_read(input logic eng, input logic [1:0] addr, output logic [31:0] data);
    cfg_we = 0; cfg_engine = eng; cfg_addr = addr;
    tick();
    data = cfg_rdata;
  endtask

  task automatic grant(input logic eng);
    active_engine = eng; engine_valid = 1; operation_in_course = 1;
    tick();
  endtask

  task automatic release_grant();
    engine_valid = 0; beat_valid = 0; pause_req = 0;
    tick();
  endtask

  task automatic beats(input int n, input int bytes);
    beat_valid = 1; beat_bytes = 6'(bytes);
    repeat (n) tick();
    beat_valid = 0;
  endtask

  typedef struct {
    logic        we;
    logic        eng;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[15];

  logic [31:0] rd;

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 2'd0, 32'd5,    32'd0};
    vecs[1]  = '{1'b0, 1'b0, 2'd0, 32'd0,    32'd5};
    vecs[2]  = '{1'b1, 1'b1, 2'd1, 32'd1234, 32'd0};
    vecs[3]  = '{1'b0, 1'b1, 2'd1, 32'd0,    32'd1234};
    vecs[4]  = '{1'b0, 1'b1, 2'd2, 32'd0,    32'h08};
    vecs[5]  = '{1'b0, 1'b0, 2'd2, 32'd0,    32'h09};
    vecs[6]  = '{1'b0, 1'b1, 2'd3, 32'd0,    32'd0};
    vecs[7]  = '{1'b1, 1'b1, 2'd0, 32'd3,    32'd0};
    vecs[8]  = '{1'b0, 1'b1, 2'd0, 32'd0,    32'd3};
    vecs[9]  = '{1'b0, 1'b1, 2'd2, 32'd0,    32'h09};
    vecs[10] = '{1'b1, 1'b1, 2'd1, 32'd77,   32'd0};
    vecs[11] = '{1'b0, 1'b1, 2'd0, 32'd0,    32'd1};
    vecs[12] = '{1'b0, 1'b1, 2'd2, 32'd0,    32'h01};
    vecs[13] = '{1'b1, 1'b0, 2'd0, 32'd8,    32'd0};
    vecs[14] = '{1'b0, 1'b0, 2'd0, 32'd0,    32'd0};

    rst_n = 0; cfg_we = 0; cfg_engine = 0; cfg_addr = 0; cfg_wdata = 0; active_engine = 0;
    engine_valid = 0; operation_in_course = 0; pause_req = 0; beat_valid = 0; beat_bytes = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_status", 32'(status_byte), 32'h0);
    check("rst_control", 32'(control_byte), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_enable", 32'(enable_engines), 32'h0);
    check("rst_rdata", cfg_rdata, 32'h0);
    check("rst_err", 32'(cfg_err), 32'h0);
    rst_n = 1;

    for (int i = 0; i < 15; i++) begin
      if (vecs[i].we) cfg_write(vecs[i].eng, vecs[i].addr, vecs[i].wdata);
      else begin
        cfg_read(vecs[i].eng, vecs[i].addr, rd);
        check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
      end
    end

    // Length runs out after four 32-byte beats.
    cfg_write(0, 2'd1, 32'd100);
    cfg_write(0, 2'd0, 32'd1);
    grant(0);
    beats(3, 32);
    check("t1_eop_early", 32'(control_byte[3]), 32'd0);
    beats(1, 32);
    check("t1_eop", 32'(control_byte[3]), 32'd1);
    release_grant();
    check("t1_eop_clear", 32'(control_byte[3]), 32'd0);
    cfg_read(0, 2'd3, rd); check("t1_done", rd, 32'd100);
    cfg_read(0, 2'd1, rd); check("t1_rem", rd, 32'd0);

    // Quantum forces end after the 66th 63-byte beat.
    cfg_write(0, 2'd1, 32'd10000);
    grant(0);
    beats(65, 63);
    check("t2_eop_early", 32'(control_byte[3]), 32'd0);
    beats(1, 63);
    check("t2_eop", 32'(control_byte[3]), 32'd1);
    cfg_read(0, 2'd1, rd); check("t2_rem", rd, 32'd5842);
    cfg_read(0, 2'd3, rd); check("t2_done", rd, 32'd4158);
    release_grant();

    // Pause blocks counting; CONTROL_BYTE[5] lags by one cycle.
    grant(0);
    pause_req = 1; beat_valid = 1; beat_bytes = 6'd63;
    #1 check("t3_pause_lag", 32'(control_byte[5]), 32'd0);
    tick();
    check("t3_pause_on", 32'(control_byte[5]), 32'd1);
    repeat (4) tick();
    pause_req = 0; beat_valid = 0;
    tick();
    check("t3_pause_off", 32'(control_byte[5]), 32'd0);
    cfg_read(0, 2'd3, rd); check("t3_done", rd, 32'd4158);
    cfg_read(0, 2'd1, rd); check("t3_rem", rd, 32'd5842);
    release_grant();

    // LENGTH write to the running engine is rejected; to the other engine accepted.
    cfg_write(1, 2'd1, 32'd500);
    cfg_write(1, 2'd0, 32'd1);
    grant(1);
    cfg_write(1, 2'd1, 32'd7);
    check("t4_err", 32'(cfg_err), 32'd1);
    tick();
    check("t4_err_pulse", 32'(cfg_err), 32'd0);
    cfg_read(1, 2'd1, rd); check("t4_len_kept", rd, 32'd500);
    cfg_write(0, 2'd1, 32'd300);
    check("t4_err_other", 32'(cfg_err), 32'd0);
    cfg_read(0, 2'd1, rd); check("t4_len_other", rd, 32'd300);
    cfg_write(1, 2'd0, 32'd3);
    check("t4_stop_same", 32'(control_byte[3]), 32'd0);
    tick();
    check("t4_stop_end", 32'(control_byte[3]), 32'd1);
    release_grant();

    // Interrupt on completion, cleared by CTRL[3]; same-cycle set beats clear.
    cfg_write(0, 2'd0, 32'hD);
    check("t5_irq_cleared", 32'(irq[0]), 32'd0);
    grant(0);
    beats(4, 63);
    check("t5_irq_early", 32'(irq[0]), 32'd0);
    beats(1, 63);
    check("t5_irq", 32'(irq[0]), 32'd1);
    release_grant();
    cfg_read(0, 2'd3, rd); check("t5_done", rd, 32'd300);
    cfg_write(0, 2'd0, 32'hD);
    check("t5_irq_clear", 32'(irq[0]), 32'd0);
    cfg_write(0, 2'd1, 32'd10);
    grant(0);
    cfg_we = 1; cfg_engine = 0; cfg_addr = 2'd0; cfg_wdata = 32'hD;
    beat_valid = 1; beat_bytes = 6'd20;
    tick();
    cfg_we = 0; beat_valid = 0;
    check("t5_set_wins", 32'(irq[0]), 32'd1);
    release_grant();
    cfg_write(0, 2'd0, 32'hD);

    // Reset in the middle of a run.
    cfg_write(1, 2'd1, 32'd1000);
    cfg_write(1, 2'd0, 32'd1);
    grant(1);
    beats(3, 10);
    pause_req = 1;
    tick();
    check("t6_pre_ctrl", 32'(control_byte), 32'h20);
    rst_n = 0;
    #1;
    check("t6_status", 32'(status_byte), 32'h0);
    check("t6_control", 32'(control_byte), 32'h0);
    check("t6_irq", 32'(irq), 32'h0);
    check("t6_enable", 32'(enable_engines), 32'h0);
    model_reset();
    engine_valid = 0; pause_req = 0; beat_valid = 0;
    @(posedge clk);
    #1 rst_n = 1;
    cfg_read(1, 2'd1, rd); check("t6_len", rd, 32'd0);
    cfg_read(1, 2'd3, rd); check("t6_done", rd, 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if (!engine_valid && $urandom_range(3) == 0) active_engine = 1'($urandom_range(1));
      if ($urandom_range(9) == 0) engine_valid = !engine_valid;
      operation_in_course = ($urandom_range(4) != 0);
      pause_req  = ($urandom_range(4) == 0);
      beat_valid = ($urandom_range(9) < 6);
      beat_bytes = 6'($urandom_range(63));
      cfg_we     = ($urandom_range(7) == 0);
      cfg_engine = 1'($urandom_range(1));
      cfg_addr   = 2'($urandom_range(3));
      cfg_wdata  = (cfg_addr == 2'd1) ? 32'($urandom_range(600)) : $urandom;
      if (cfg_addr == 2'd0 && $urandom_range(3) != 0) cfg_wdata = (cfg_wdata & ~32'h2) | 32'h1;
      tick();
    end
    cfg_we = 0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
